// File: rtl/medium_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the data, weight and heap media.
// Optional statistics ports are built when MEDIUM_ARBITER_STATS_EN is defined.
module medium_arbiter #(
    parameter int unsigned DATA_LENGTH   = 256,
    parameter int unsigned WEIGHT_LENGTH = 256,
    parameter int unsigned HEAP_LENGTH   = 256,
    parameter int unsigned WORD_SIZE     = 1024,
    parameter int unsigned MEM_ADDR_SIZE = 11,
    parameter int unsigned DATA_BASE     = 0,
    parameter int unsigned WEIGHT_BASE   = 512,
    parameter int unsigned HEAP_BASE     = 768,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [$clog2(DATA_LENGTH)-1:0]   data_addr_in,
    input  logic                             data_read_enable_in,
    output logic [WORD_SIZE-1:0]             data_x_out,
    output logic [WORD_SIZE-1:0]             data_y_out,
    output logic                             data_finished_out,
    input  logic [$clog2(WEIGHT_LENGTH)-1:0] weight_addr_in,
    input  logic [WORD_SIZE-1:0]             weight_in,
    input  logic                             weight_read_enable_in,
    input  logic                             weight_write_enable_in,
    output logic [WORD_SIZE-1:0]             weight_out,
    output logic                             weight_finished_out,
    input  logic [$clog2(HEAP_LENGTH)-1:0]   heap_addr_in,
    input  logic [WORD_SIZE-1:0]             heap_in,
    input  logic                             heap_read_enable_in,
    input  logic                             heap_write_enable_in,
    output logic [WORD_SIZE-1:0]             heap_out,
    output logic                             heap_finished_out,
    output logic [MEM_ADDR_SIZE-1:0]         mem_addr_out,
    output logic [WORD_SIZE-1:0]             mem_wdata_out,
    output logic                             mem_en_out,
    output logic                             mem_we_out,
    input  logic [WORD_SIZE-1:0]             mem_rdata_in,
    output logic                             error_out
`ifdef MEDIUM_ARBITER_STATS_EN
    ,
    output logic [31:0]                      stall_count_out,
    output logic [2:0][15:0]                 grant_count_out
`endif
);

    localparam int unsigned DATA_AW   = $clog2(DATA_LENGTH);
    localparam int unsigned WEIGHT_AW = $clog2(WEIGHT_LENGTH);
    localparam int unsigned HEAP_AW   = $clog2(HEAP_LENGTH);

    localparam logic [1:0] REQ_DATA   = 2'd0;
    localparam logic [1:0] REQ_WEIGHT = 2'd1;
    localparam logic [1:0] REQ_HEAP   = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ISSUE_Y, S_WAIT, S_DONE} state_t;

    state_t                   state;
    logic [1:0]               ptr;
    logic [1:0]               grant;
    logic                     svc_write;

    logic [2:0]               pending;
    logic [2:0]               req;
    logic [2:0]               busy;
    logic [DATA_AW-1:0]       data_addr_q;
    logic [WEIGHT_AW-1:0]     weight_addr_q;
    logic [HEAP_AW-1:0]       heap_addr_q;
    logic                     weight_write_q;
    logic                     heap_write_q;
    logic [WORD_SIZE-1:0]     weight_wdata_q;
    logic [WORD_SIZE-1:0]     heap_wdata_q;

    logic                     gnt_valid;
    logic [1:0]               gnt_idx;
    logic [1:0]               cand;
    logic [MEM_ADDR_SIZE-1:0] gnt_addr;
    logic                     gnt_write;
    logic [WORD_SIZE-1:0]     gnt_wdata;

    logic [READ_LATENCY-1:0]  rd_vld;
    logic [READ_LATENCY-1:0]  rd_is_y;
    logic                     rd_last;

    assign req = {heap_read_enable_in | heap_write_enable_in,
                  weight_read_enable_in | weight_write_enable_in,
                  data_read_enable_in};

    // A requester is busy while pending or while it owns the BRAM sequence.
    always_comb begin
        busy = pending;
        if (state != S_IDLE) begin
            busy[grant] = 1'b1;
        end
    end

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = REQ_DATA;
        cand      = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!gnt_valid && pending[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == REQ_HEAP) ? REQ_DATA : cand + 2'd1;
        end
    end

    always_comb begin
        gnt_addr  = '0;
        gnt_write = 1'b0;
        gnt_wdata = '0;
        case (gnt_idx)
            REQ_WEIGHT: begin
                gnt_addr  = MEM_ADDR_SIZE'(WEIGHT_BASE + 32'(weight_addr_q));
                gnt_write = weight_write_q;
                gnt_wdata = weight_wdata_q;
            end
            REQ_HEAP: begin
                gnt_addr  = MEM_ADDR_SIZE'(HEAP_BASE + 32'(heap_addr_q));
                gnt_write = heap_write_q;
                gnt_wdata = heap_wdata_q;
            end
            default: begin
                gnt_addr  = MEM_ADDR_SIZE'(DATA_BASE + 32'd2 * 32'(data_addr_q));
            end
        endcase
    end

    // Request capture; a repeat request from a busy requester is dropped and flagged.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending        <= '0;
            error_out      <= 1'b0;
            data_addr_q    <= '0;
            weight_addr_q  <= '0;
            heap_addr_q    <= '0;
            weight_write_q <= 1'b0;
            heap_write_q   <= 1'b0;
            weight_wdata_q <= '0;
            heap_wdata_q   <= '0;
        end else begin
            if (state == S_IDLE && gnt_valid) begin
                pending[gnt_idx] <= 1'b0;
            end
            if (req[0]) begin
                if (busy[0]) begin
                    error_out <= 1'b1;
                end else begin
                    pending[0]  <= 1'b1;
                    data_addr_q <= data_addr_in;
                end
            end
            if (req[1]) begin
                if (busy[1]) begin
                    error_out <= 1'b1;
                end else begin
                    pending[1]     <= 1'b1;
                    weight_addr_q  <= weight_addr_in;
                    weight_write_q <= weight_write_enable_in;
                    weight_wdata_q <= weight_in;
                end
            end
            if (req[2]) begin
                if (busy[2]) begin
                    error_out <= 1'b1;
                end else begin
                    pending[2]   <= 1'b1;
                    heap_addr_q  <= heap_addr_in;
                    heap_write_q <= heap_write_enable_in;
                    heap_wdata_q <= heap_in;
                end
            end
        end
    end

    assign rd_last = rd_vld[READ_LATENCY-1] && (grant != REQ_DATA || rd_is_y[READ_LATENCY-1]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= S_IDLE;
            ptr                 <= REQ_DATA;
            grant               <= REQ_DATA;
            svc_write           <= 1'b0;
            mem_addr_out        <= '0;
            mem_wdata_out       <= '0;
            mem_en_out          <= 1'b0;
            mem_we_out          <= 1'b0;
            data_finished_out   <= 1'b0;
            weight_finished_out <= 1'b0;
            heap_finished_out   <= 1'b0;
        end else begin
            mem_en_out          <= 1'b0;
            mem_we_out          <= 1'b0;
            data_finished_out   <= 1'b0;
            weight_finished_out <= 1'b0;
            heap_finished_out   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        grant        <= gnt_idx;
                        ptr          <= (gnt_idx == REQ_HEAP) ? REQ_DATA : gnt_idx + 2'd1;
                        svc_write    <= gnt_write;
                        mem_en_out   <= 1'b1;
                        mem_we_out   <= gnt_write;
                        mem_addr_out <= gnt_addr;
                        if (gnt_write) begin
                            mem_wdata_out <= gnt_wdata;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (svc_write) begin
                        weight_finished_out <= (grant == REQ_WEIGHT);
                        heap_finished_out   <= (grant == REQ_HEAP);
                        state               <= S_DONE;
                    end else if (grant == REQ_DATA) begin
                        mem_en_out   <= 1'b1;
                        mem_addr_out <= mem_addr_out + MEM_ADDR_SIZE'(1);
                        state        <= S_ISSUE_Y;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_ISSUE_Y: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_last) begin
                        data_finished_out   <= (grant == REQ_DATA);
                        weight_finished_out <= (grant == REQ_WEIGHT);
                        heap_finished_out   <= (grant == REQ_HEAP);
                        state               <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read pipeline tracks each issued read until its data arrives from the BRAM.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_vld     <= '0;
            rd_is_y    <= '0;
            data_x_out <= '0;
            data_y_out <= '0;
            weight_out <= '0;
            heap_out   <= '0;
        end else begin
            rd_vld[0]  <= mem_en_out & ~mem_we_out;
            rd_is_y[0] <= (state == S_ISSUE_Y);
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                rd_vld[i]  <= rd_vld[i-1];
                rd_is_y[i] <= rd_is_y[i-1];
            end
            if (rd_vld[READ_LATENCY-1]) begin
                case (grant)
                    REQ_WEIGHT: weight_out <= mem_rdata_in;
                    REQ_HEAP:   heap_out   <= mem_rdata_in;
                    default: begin
                        if (rd_is_y[READ_LATENCY-1]) begin
                            data_y_out <= mem_rdata_in;
                        end else begin
                            data_x_out <= mem_rdata_in;
                        end
                    end
                endcase
            end
        end
    end

`ifdef MEDIUM_ARBITER_STATS_EN
    // Saturating stall and per-requester grant counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_count_out <= '0;
            grant_count_out <= '0;
        end else begin
            if ((|pending) && state != S_IDLE && stall_count_out != '1) begin
                stall_count_out <= stall_count_out + 32'd1;
            end
            if (state == S_IDLE && gnt_valid && grant_count_out[gnt_idx] != '1) begin
                grant_count_out[gnt_idx] <= grant_count_out[gnt_idx] + 16'd1;
            end
        end
    end
`endif

endmodule
